// File: rtl/dual_port_ram_pkg.sv
// Shared constants and the byte-merge helper for the byte-enable dual-port RAM.
package dual_port_ram_pkg;

    localparam int unsigned READ_LATENCY_MIN = 1;
    localparam int unsigned READ_LATENCY_MAX = 4;

    // Widest word byte_merge can handle; callers zero-extend and truncate around it
    localparam int unsigned MERGE_MAX_W = 256;
    localparam int unsigned MERGE_IDX_W = 8;

    localparam string RDW_READ_FIRST  = "read_first";
    localparam string RDW_WRITE_FIRST = "write_first";
    localparam string RDW_NO_CHANGE   = "no_change";

    function automatic logic [MERGE_MAX_W-1:0] byte_merge(
        input logic [MERGE_MAX_W-1:0] old_word,
        input logic [MERGE_MAX_W-1:0] new_word,
        input logic [MERGE_MAX_W-1:0] byte_en,
        input int unsigned            byte_w
    );
        logic [MERGE_MAX_W-1:0] merged;
        merged = old_word;
        for (int unsigned i = 0; i < MERGE_MAX_W; i++) begin
            if (byte_en[MERGE_IDX_W'(i / byte_w)]) begin
                merged[MERGE_IDX_W'(i)] = new_word[MERGE_IDX_W'(i)];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dual_port_ram_be_read_pipe.sv
// Per-port read pipeline: READ_LATENCY-deep data/valid shift register.
module ram_read_pipe
    import dual_port_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid
);

    logic [READ_LATENCY-1:0] r_valid;
    logic [DATA_WIDTH-1:0]   r_data [READ_LATENCY];

    // Data stages only load alongside a valid beat so the last stage holds between beats
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= '0;
            for (int k = 0; k < int'(READ_LATENCY); k++) begin
                r_data[k] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            if (i_valid) begin
                r_data[0] <= i_data;
            end
            for (int k = 1; k < int'(READ_LATENCY); k++) begin
                r_valid[k] <= r_valid[k-1];
                if (r_valid[k-1]) begin
                    r_data[k] <= r_data[k-1];
                end
            end
        end
    end

    assign o_data  = r_data[READ_LATENCY-1];
    assign o_valid = r_valid[READ_LATENCY-1];

endmodule

// File: rtl/dual_port_ram_be.sv
// True dual-port block RAM, single clock, byte write enables, configurable latency and RDW mode.
module dual_port_ram_be
    import dual_port_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned BYTE_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned READ_LATENCY = 2,
    parameter string       RDW_MODE     = "read_first",
    parameter string       INIT_FILE    = ""
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_en_a,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]    i_wr_en_a,
    input  logic [ADDR_WIDTH-1:0]               i_addr_a,
    input  logic [DATA_WIDTH-1:0]               i_data_a,
    output logic [DATA_WIDTH-1:0]               o_data_a,
    output logic                                o_data_en_a,
    input  logic                                i_en_b,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]    i_wr_en_b,
    input  logic [ADDR_WIDTH-1:0]               i_addr_b,
    input  logic [DATA_WIDTH-1:0]               i_data_b,
    output logic [DATA_WIDTH-1:0]               o_data_b,
    output logic                                o_data_en_b,
    output logic                                o_collision
);

    localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
    localparam bit          IS_WF     = (RDW_MODE == RDW_WRITE_FIRST);
    localparam bit          IS_NC     = (RDW_MODE == RDW_NO_CHANGE);

    if (BYTE_WIDTH == 0 || (DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_err_width
        $fatal(1, "DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (DATA_WIDTH > MERGE_MAX_W) begin : g_err_max
        $fatal(1, "DATA_WIDTH exceeds byte_merge capacity");
    end
    if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX) begin : g_err_lat
        $fatal(1, "READ_LATENCY must be within 1..4");
    end
    if (RDW_MODE != RDW_READ_FIRST && RDW_MODE != RDW_WRITE_FIRST &&
        RDW_MODE != RDW_NO_CHANGE) begin : g_err_rdw
        $fatal(1, "unknown RDW_MODE");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};
    logic                  r_collision;

    logic                  w_wr_a;
    logic                  w_wr_b;
    logic                  w_same_wr;
    logic [DATA_WIDTH-1:0] w_old_a;
    logic [DATA_WIDTH-1:0] w_old_b;
    logic [DATA_WIDTH-1:0] w_own_a;
    logic [DATA_WIDTH-1:0] w_own_b;
    logic [DATA_WIDTH-1:0] w_word_a;
    logic [DATA_WIDTH-1:0] w_rd_a;
    logic [DATA_WIDTH-1:0] w_rd_b;
    logic                  w_rd_vld_a;
    logic                  w_rd_vld_b;

    assign w_wr_a    = i_en_a && (|i_wr_en_a);
    assign w_wr_b    = i_en_b && (|i_wr_en_b);
    assign w_same_wr = w_wr_a && w_wr_b && (i_addr_a == i_addr_b);
    assign w_old_a   = r_mem[i_addr_a];
    assign w_old_b   = r_mem[i_addr_b];

    assign w_own_a = DATA_WIDTH'(byte_merge(MERGE_MAX_W'(w_old_a), MERGE_MAX_W'(i_data_a),
                                            MERGE_MAX_W'(i_wr_en_a), BYTE_WIDTH));
    assign w_own_b = DATA_WIDTH'(byte_merge(MERGE_MAX_W'(w_old_b), MERGE_MAX_W'(i_data_b),
                                            MERGE_MAX_W'(i_wr_en_b), BYTE_WIDTH));

    // On a same-address double write, A merges on top of B's result so B keeps its own bytes
    assign w_word_a = w_same_wr
        ? DATA_WIDTH'(byte_merge(MERGE_MAX_W'(w_own_b), MERGE_MAX_W'(i_data_a),
                                 MERGE_MAX_W'(i_wr_en_a), BYTE_WIDTH))
        : w_own_a;

    // A is written last so its overlapping bytes win
    always_ff @(posedge i_clk) begin
        if (w_wr_b) begin
            r_mem[i_addr_b] <= w_own_b;
        end
        if (w_wr_a) begin
            r_mem[i_addr_a] <= w_word_a;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_collision <= 1'b0;
        end else begin
            r_collision <= w_same_wr;
        end
    end

    assign o_collision = r_collision;

    assign w_rd_vld_a = i_en_a && !(IS_NC && w_wr_a);
    assign w_rd_vld_b = i_en_b && !(IS_NC && w_wr_b);
    assign w_rd_a     = (IS_WF && w_wr_a) ? w_own_a : w_old_a;
    assign w_rd_b     = (IS_WF && w_wr_b) ? w_own_b : w_old_b;

    ram_read_pipe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_pipe_a (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_valid(w_rd_vld_a),
        .i_data (w_rd_a),
        .o_data (o_data_a),
        .o_valid(o_data_en_a)
    );

    ram_read_pipe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_pipe_b (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_valid(w_rd_vld_b),
        .i_data (w_rd_b),
        .o_data (o_data_b),
        .o_valid(o_data_en_b)
    );

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Directed bench for dual_port_ram_be: three instances (one per RDW mode) share one stimulus.
module tb_dual_port_ram_be;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, en_b;
    logic [3:0]  we_a, we_b;
    logic [9:0]  addr_a, addr_b;
    logic [31:0] data_a, data_b;

    logic [31:0] rf_da, rf_db, wf_da, wf_db, nc_da, nc_db;
    logic        rf_va, rf_vb, wf_va, wf_vb, nc_va, nc_vb;
    logic        rf_col, wf_col, nc_col;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    always #5 clk = ~clk;

    dual_port_ram_be #(.READ_LATENCY(2), .RDW_MODE("read_first")) u_rf (
        .i_clk(clk), .i_rst(rst),
        .i_en_a(en_a), .i_wr_en_a(we_a), .i_addr_a(addr_a), .i_data_a(data_a),
        .o_data_a(rf_da), .o_data_en_a(rf_va),
        .i_en_b(en_b), .i_wr_en_b(we_b), .i_addr_b(addr_b), .i_data_b(data_b),
        .o_data_b(rf_db), .o_data_en_b(rf_vb), .o_collision(rf_col)
    );

    dual_port_ram_be #(.READ_LATENCY(2), .RDW_MODE("write_first")) u_wf (
        .i_clk(clk), .i_rst(rst),
        .i_en_a(en_a), .i_wr_en_a(we_a), .i_addr_a(addr_a), .i_data_a(data_a),
        .o_data_a(wf_da), .o_data_en_a(wf_va),
        .i_en_b(en_b), .i_wr_en_b(we_b), .i_addr_b(addr_b), .i_data_b(data_b),
        .o_data_b(wf_db), .o_data_en_b(wf_vb), .o_collision(wf_col)
    );

    dual_port_ram_be #(.READ_LATENCY(2), .RDW_MODE("no_change")) u_nc (
        .i_clk(clk), .i_rst(rst),
        .i_en_a(en_a), .i_wr_en_a(we_a), .i_addr_a(addr_a), .i_data_a(data_a),
        .o_data_a(nc_da), .o_data_en_a(nc_va),
        .i_en_b(en_b), .i_wr_en_b(we_b), .i_addr_b(addr_b), .i_data_b(data_b),
        .o_data_b(nc_db), .o_data_en_b(nc_vb), .o_collision(nc_col)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en_a = 1'b0; we_a = '0; en_b = 1'b0; we_b = '0;
    endtask

    task automatic drive_a(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] we);
        en_a = 1'b1; addr_a = addr; data_a = data; we_a = we;
    endtask

    task automatic drive_b(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] we);
        en_b = 1'b1; addr_b = addr; data_b = data; we_b = we;
    endtask

    task automatic settle(input int n);
        idle();
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;

        // Reset held 3 cycles while both ports issue reads
        drive_a(10'h000, 32'h0, 4'h0);
        drive_b(10'h001, 32'h0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_va", 32'(rf_va), 32'd0);
            check("rst_vb", 32'(rf_vb), 32'd0);
        end
        check("rst_da", rf_da, 32'h0);
        check("rst_db", rf_db, 32'h0);
        check("rst_col", 32'(rf_col), 32'd0);
        rst = 1'b0;
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_va", 32'(rf_va), 32'd0);
            check("post_rst_vb", 32'(rf_vb), 32'd0);
        end

        // Preload through port A
        drive_a(10'h010, 32'hDEADBEEF, 4'hF); tick();
        drive_a(10'h011, 32'hCAFEF00D, 4'hF); tick();
        drive_a(10'h020, 32'hAABBCCDD, 4'hF); tick();
        drive_a(10'h030, 32'h12ABCDEF, 4'hF); tick();
        settle(4);

        // Single read latency and hold
        drive_a(10'h010, 32'h0, 4'h0); tick(); idle();
        check("lat_c1_va", 32'(rf_va), 32'd0);
        tick();
        check("lat_c2_va", 32'(rf_va), 32'd1);
        check("lat_c2_da", rf_da, 32'hDEADBEEF);
        tick();
        check("lat_c3_va", 32'(rf_va), 32'd0);
        check("hold_da", rf_da, 32'hDEADBEEF);

        // Back-to-back reads
        drive_a(10'h010, 32'h0, 4'h0); tick();
        check("b2b_c1_va", 32'(rf_va), 32'd0);
        drive_a(10'h011, 32'h0, 4'h0); tick(); idle();
        check("b2b_c2_va", 32'(rf_va), 32'd1);
        check("b2b_c2_da", rf_da, 32'hDEADBEEF);
        tick();
        check("b2b_c3_va", 32'(rf_va), 32'd1);
        check("b2b_c3_da", rf_da, 32'hCAFEF00D);
        tick();
        check("b2b_c4_va", 32'(rf_va), 32'd0);
        settle(2);

        // Byte-enable write with same-port RDW in all three modes
        drive_a(10'h020, 32'h11223344, 4'b0101); tick(); idle(); tick();
        check("rdw_rf_va", 32'(rf_va), 32'd1);
        check("rdw_rf_da", rf_da, 32'hAABBCCDD);
        check("rdw_wf_va", 32'(wf_va), 32'd1);
        check("rdw_wf_da", wf_da, 32'hAA22CC44);
        check("rdw_nc_va", 32'(nc_va), 32'd0);
        check("rdw_nc_hold", nc_da, 32'hCAFEF00D);
        settle(3);
        drive_a(10'h020, 32'h0, 4'h0); tick(); idle(); tick();
        check("bw_rd_va", 32'(rf_va), 32'd1);
        check("bw_rd_da", rf_da, 32'hAA22CC44);
        check("bw_rd_nc", nc_da, 32'hAA22CC44);
        settle(3);

        // Same-address double write: A wins on byte 1
        drive_a(10'h030, 32'h000000FF, 4'b0011);
        drive_b(10'h030, 32'h12345678, 4'b0110);
        tick(); idle();
        check("col_set", 32'(rf_col), 32'd1);
        tick();
        check("col_clear", 32'(rf_col), 32'd0);
        settle(3);
        drive_b(10'h030, 32'h0, 4'h0); tick(); idle(); tick();
        check("col_word", rf_db, 32'h123400FF);

        // Disjoint bytes at the same address still collide; different addresses do not
        drive_a(10'h050, 32'h0, 4'b0001);
        drive_b(10'h050, 32'h0, 4'b1000);
        tick(); idle();
        check("col_disjoint", 32'(rf_col), 32'd1);
        drive_a(10'h051, 32'h0, 4'b0001);
        drive_b(10'h052, 32'h0, 4'b0001);
        tick(); idle();
        check("col_diff_addr", 32'(rf_col), 32'd0);
        settle(3);

        // Cross-port: B reads the old word during A's write, the new word next cycle
        drive_a(10'h040, 32'h55555555, 4'hF);
        drive_b(10'h040, 32'h0, 4'h0);
        tick();
        idle();
        drive_b(10'h040, 32'h0, 4'h0);
        tick(); idle();
        check("xp_old_vb", 32'(rf_vb), 32'd1);
        check("xp_old_rf", rf_db, 32'h0);
        check("xp_old_wf", wf_db, 32'h0);
        check("xp_old_nc", nc_db, 32'h0);
        tick();
        check("xp_new_vb", 32'(rf_vb), 32'd1);
        check("xp_new_rf", rf_db, 32'h55555555);
        tick();
        check("xp_end_vb", 32'(rf_vb), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
